// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX-stage operand forwarding selects, load-use detection and
// multiply/divide busy tracking for the 5-stage MIPS pipeline. Stall and flush
// are raised together whenever the instruction in ID cannot advance.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_use,
  input  logic       id_rt_use,
  input  logic       id_md_use,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_wreg,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic       ex_md_start,
  input  logic       ex_md_div,
  input  logic [4:0] mem_wreg,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic [4:0] wb_wreg,
  input  logic       wb_regwrite,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b,
  output logic       stall,
  output logic       flush,
  output logic       md_busy,
  output logic       md_err
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  // Operand mux select encoding seen by the EX stage.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_md_busy;
  logic             r_md_err;
  logic             w_load_use;
  logic             w_md_stall;
  logic             w_bad_start;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;

  // Pick the youngest valid producer for one EX source register. A load in
  // MEM has no data yet, so it is skipped; $0 is hard-wired and never bypassed.
  function automatic fwd_sel_e fwd_pick(
    input logic [4:0] src,
    input logic [4:0] m_wreg,
    input logic       m_regwrite,
    input logic       m_memread,
    input logic [4:0] w_wreg,
    input logic       w_regwrite
  );
    if (m_regwrite && !m_memread && (m_wreg != 5'd0) && (m_wreg == src))
      return FWD_MEM;
    else if (w_regwrite && (w_wreg != 5'd0) && (w_wreg == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Per-operand forwarding selects, MEM taking priority over WB.
  always_comb begin
    w_fwd_a = fwd_pick(ex_rs, mem_wreg, mem_regwrite, mem_memread, wb_wreg, wb_regwrite);
    w_fwd_b = fwd_pick(ex_rt, mem_wreg, mem_regwrite, mem_memread, wb_wreg, wb_regwrite);
  end

  assign forward_a = w_fwd_a;
  assign forward_b = w_fwd_b;

  // Hazard detection: a load in EX feeding ID, or an MD user meeting a busy
  // or just-starting MD unit. Both collapse into one stall/flush.
  always_comb begin
    w_load_use = ex_memread && ex_regwrite && (ex_wreg != 5'd0) &&
                 ((id_rs_use && (id_rs == ex_wreg)) ||
                  (id_rt_use && (id_rt == ex_wreg)));
    w_md_stall = id_md_use && (r_md_busy || ex_md_start);
  end

  assign stall = w_load_use || w_md_stall;
  assign flush = w_load_use || w_md_stall;

  // Next MD count: load on an accepted start, otherwise count down to zero.
  // A start that arrives while busy is dropped and only flagged.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_cnt_next  = r_cnt;
    w_bad_start = 1'b0;
    if (ex_md_start && (r_cnt == '0)) begin
      w_cnt_next = ex_md_div ? DIV_LOAD : MULT_LOAD;
    end else begin
      w_bad_start = ex_md_start;
      if (r_cnt != '0)
        w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

  // MD counter and a registered busy flag, so md_busy comes straight off a flop.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (!reset) begin
      r_cnt     <= '0;
      r_md_busy <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_md_busy <= (w_cnt_next != '0);
    end
  end

  // Sticky error: set by any start pulse that lands while the unit is busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_md_err <= 1'b0;
    else if (w_bad_start)
      r_md_err <= 1'b1;
  end

  assign md_busy = r_md_busy;
  assign md_err  = r_md_err;

endmodule
